// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: UART transmitter FSM states, frame constants
// and the default baud divisor.
package mini_src_pkg;

    localparam int UART_FRAME_DATA_BITS = 8;
    localparam int CLKS_PER_BIT         = 434;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/outport_uart_tx_if.sv
// Write-side and status signals of the OUTPORT UART transmitter.
// The master is the CPU/OUTPORT side; the slave is the transmitter.
interface outport_uart_tx_if;
    import mini_src_pkg::*;

    logic                            wr_en;
    logic [UART_FRAME_DATA_BITS-1:0] wr_data;
    logic                            tx;
    logic                            busy;
    logic                            full;
    logic                            overflow;

    modport master (
        output wr_en, wr_data,
        input  tx, busy, full, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output tx, busy, full, overflow
    );

endinterface

// File: rtl/outport_tx_fifo.sv
// Byte FIFO ahead of the OUTPORT UART transmitter.
// Count register plus read/write pointers; DEPTH must be a power of two.
module outport_tx_fifo
    import mini_src_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_FRAME_DATA_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/outport_uart_tx.sv
// OUTPORT UART transmitter: buffers OUTPORT writes and sends them as 8N1 frames.
// Define OUTPORT_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module outport_uart_tx
    import mini_src_pkg::*;
#(
    parameter int CLKS_PER_BIT = mini_src_pkg::CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input logic               CLOCK_50,
    input logic               reset,
    outport_uart_tx_if.slave  bus
);

    localparam int                  BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                  BIT_W     = $clog2(UART_FRAME_DATA_BITS);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(UART_FRAME_DATA_BITS - 1);

    tx_state_e                       state_q, state_d;
    logic [BAUD_W-1:0]               baud_q, baud_d;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [UART_FRAME_DATA_BITS-1:0] data_q, data_d;
    logic                            tx_q, tx_d;
    logic                            ovf_q, ovf_d;

    logic                            fifo_pop;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [UART_FRAME_DATA_BITS-1:0] fifo_data;
    logic                            baud_wrap;

    outport_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_FRAME_DATA_BITS)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .push_i  (bus.wr_en),
        .pop_i   (fifo_pop),
        .data_i  (bus.wr_data),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    data_d  = fifo_data;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_wrap) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_LAST) begin
`ifdef OUTPORT_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef OUTPORT_TX_PARITY_EN
            TX_PARITY: begin
                if (baud_wrap) begin
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (baud_wrap) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // tx follows the current state through a flop, so the line lags the FSM by one cycle.
    always_comb begin
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
        case (state_q)
            TX_IDLE:   fifo_pop = !fifo_empty;
            TX_START:  tx_d     = 1'b0;
            TX_DATA:   tx_d     = data_q[bit_q];
`ifdef OUTPORT_TX_PARITY_EN
            TX_PARITY: tx_d     = ^data_q;
`endif
            default:   tx_d     = 1'b1;
        endcase
        ovf_d = ovf_q | (bus.wr_en & fifo_full & ~fifo_pop);
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = !fifo_empty || (state_q != TX_IDLE);
    assign bus.full     = fifo_full;
    assign bus.overflow = ovf_q;

endmodule
